// File: rtl/m_len_seq_ctrl.sv
// Link-ID -> m_len sequencer: drives the lookup encoder, then streams ceil(m_len/BPC) beats; first beat 3 cycles after accept.
// Beats hold (seg_last/seg_bits stable) while seg_ready is low; LINK_ID_RANGE_CHK_EN rejects IDs outside 4..34 without touching the encoder.
module m_len_seq_ctrl #(
    parameter int BPC   = 8,
    parameter int CNT_W = 11
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   req_valid,
    input  logic [5:0]             req_link_id,
    output logic                   req_ready,
    output logic [5:0]             enc_link_id,
    output logic                   enc_id_enable,
    input  logic [12:0]            enc_m_len,
    output logic                   seg_valid,
    input  logic                   seg_ready,
    output logic                   seg_last,
    output logic [$clog2(BPC):0]   seg_bits,
    output logic [12:0]            frame_len,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int LOG2 = $clog2(BPC);
    localparam int SB_W = LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOK,
        EN,
        CAP,
        RUN,
        ERR
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   beats_left;
    logic [SB_W-1:0]    tail_bits;

    logic [13:0]        len_ext;
    logic [13:0]        beats_calc;
    logic [13:0]        rem_calc;
    logic [SB_W-1:0]    tail_calc;
    logic               id_in_range;

    // 14-bit arithmetic so len + BPC-1 cannot wrap for any 13-bit length
    assign len_ext     = {1'b0, enc_m_len};
    assign beats_calc  = (len_ext + 14'(BPC - 1)) >> LOG2;
    assign rem_calc    = len_ext & 14'(BPC - 1);
    assign tail_calc   = (rem_calc == 14'd0) ? SB_W'(BPC) : rem_calc[SB_W-1:0];
    assign id_in_range = (req_link_id >= 6'd4) && (req_link_id <= 6'd34);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            enc_link_id   <= '0;
            enc_id_enable <= 1'b0;
            seg_valid     <= 1'b0;
            seg_last      <= 1'b0;
            seg_bits      <= '0;
            frame_len     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            beats_left    <= '0;
            tail_bits     <= '0;
        end else begin
            done          <= 1'b0;
            err           <= 1'b0;
            enc_id_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef LINK_ID_RANGE_CHK_EN
                        if (!id_in_range) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            enc_link_id <= req_link_id;
                            state       <= LOOK;
                        end
`else
                        enc_link_id <= req_link_id;
                        state       <= LOOK;
`endif
                    end
                end
                LOOK: begin
                    enc_id_enable <= 1'b1;
                    state         <= EN;
                end
                EN: begin
                    state <= CAP;
                end
                CAP: begin
                    frame_len <= enc_m_len;
                    if (enc_m_len == 13'd0) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        beats_left <= CNT_W'(beats_calc);
                        tail_bits  <= tail_calc;
                        seg_valid  <= 1'b1;
                        seg_last   <= (beats_calc == 14'd1);
                        seg_bits   <= (beats_calc == 14'd1) ? tail_calc : SB_W'(BPC);
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (seg_ready) begin
                        if (beats_left == CNT_W'(1)) begin
                            state     <= IDLE;
                            seg_valid <= 1'b0;
                            seg_last  <= 1'b0;
                            seg_bits  <= '0;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            beats_left <= beats_left - CNT_W'(1);
                            seg_last   <= (beats_left == CNT_W'(2));
                            seg_bits   <= (beats_left == CNT_W'(2)) ? tail_bits : SB_W'(BPC);
                        end
                    end
                end
                ERR: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_len_seq_ctrl.sv
// Bench for m_len_seq_ctrl: encoder lookup model plus directed and random frames checked beat by beat.
module tb_m_len_seq_ctrl;

    localparam int BPC = 8;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        req_valid;
    logic [5:0]  req_link_id;
    logic        req_ready;
    logic [5:0]  enc_link_id;
    logic        enc_id_enable;
    logic [12:0] enc_m_len = '0;
    logic        seg_valid;
    logic        seg_ready;
    logic        seg_last;
    logic [3:0]  seg_bits;
    logic [12:0] frame_len;
    logic        busy;
    logic        done;
    logic        err;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [5:0]  last_enc = '0;
    logic [5:0]  enc_k    = '0;

    m_len_seq_ctrl #(.BPC(BPC), .CNT_W(11)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .req_valid     (req_valid),
        .req_link_id   (req_link_id),
        .req_ready     (req_ready),
        .enc_link_id   (enc_link_id),
        .enc_id_enable (enc_id_enable),
        .enc_m_len     (enc_m_len),
        .seg_valid     (seg_valid),
        .seg_ready     (seg_ready),
        .seg_last      (seg_last),
        .seg_bits      (seg_bits),
        .frame_len     (frame_len),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Link-ID lookup table; IDs outside 4..34 are unmapped
    function automatic int lut(input logic [5:0] id);
        case (id)
            6'h04:   return 952;
            6'h18:   return 3788;
            6'h05:   return 288;
            6'h1e:   return 5320;
            6'h14:   return 90;
            6'h0d:   return 1290;
            default: return (id >= 4 && id <= 34) ? int'(id) * 61 + 3 : 0;
        endcase
    endfunction

    // Encoder: link_id registered first, m_len updated on id_enable
    always @(posedge clk) begin
        enc_k <= enc_link_id;
        if (enc_id_enable) enc_m_len <= 13'(lut(enc_k));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle.
    task automatic frame(input logic [5:0] id, input logic [5:0] nxt, input bit hold,
                         input bit rnd, input int abort_beat);
        int len, nb, rem, beat, cyc, bound;
        bit hs;
        len   = lut(id);
        nb    = (len + BPC - 1) / BPC;
        rem   = (len % BPC == 0) ? BPC : len % BPC;
        bound = rnd ? 4 * nb + 50 : nb + 5;
        req_valid   = 1'b1;
        req_link_id = id;
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        if (hold) req_link_id = nxt;
        else begin
            req_valid   = 1'b0;
            req_link_id = 6'($urandom);
        end
        @(negedge clk);
`ifdef LINK_ID_RANGE_CHK_EN
        if (id < 4 || id > 34) begin
            chk("early_err", err, 1);
            chk("early_no_en", enc_id_enable, 0);
            chk("early_enc_hold", enc_link_id, last_enc);
            chk("early_busy", busy, 1);
            @(negedge clk);
            chk("early_err_pulse", err, 0);
            chk("early_ready", req_ready, 1);
            chk("early_no_valid", seg_valid, 0);
            return;
        end
`endif
        chk("look_busy", busy, 1);
        chk("look_ready", req_ready, 0);
        chk("look_no_en", enc_id_enable, 0);
        @(negedge clk);
        chk("en_pulse", enc_id_enable, 1);
        chk("en_link_id", enc_link_id, id);
        last_enc = id;
        @(negedge clk);
        chk("cap_en_low", enc_id_enable, 0);
        chk("cap_no_valid", seg_valid, 0);
        @(negedge clk);
        if (len == 0) begin
            chk("zero_err", err, 1);
            chk("zero_no_valid", seg_valid, 0);
            chk("zero_frame_len", frame_len, 0);
            @(negedge clk);
            chk("zero_err_pulse", err, 0);
            chk("zero_ready", req_ready, 1);
            chk("zero_busy", busy, 0);
            chk("zero_no_valid2", seg_valid, 0);
            return;
        end
        beat = 1;
        cyc  = 0;
        while (beat <= nb && cyc < bound) begin
            chk("beat_valid", seg_valid, 1);
            chk("beat_last", seg_last, (beat == nb) ? 1 : 0);
            chk("beat_bits", seg_bits, (beat == nb) ? rem : BPC);
            if (beat == 1) chk("frame_len_run", frame_len, len);
            if (beat == abort_beat) begin
                n_rst     = 1'b0;
                seg_ready = 1'b1;
                @(posedge clk); #1;
                n_rst = 1'b1;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_valid", seg_valid, 0);
                chk("abort_ready", req_ready, 1);
                chk("abort_done", done, 0);
                chk("abort_frame_len", frame_len, 0);
                chk("abort_enc_id", enc_link_id, 0);
                last_enc = '0;
                @(negedge clk);
                chk("abort_done_later", done, 0);
                chk("abort_err_later", err, 0);
                return;
            end
            seg_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            hs = seg_ready;
            @(negedge clk);
            if (hs) beat++;
            cyc++;
        end
        chk("frame_beats_in_budget", beat, nb + 1);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_ready", req_ready, 1);
        chk("done_valid_low", seg_valid, 0);
        chk("done_frame_len", frame_len, len);
        seg_ready = 1'b0;
        if (!hold) begin
            @(negedge clk);
            chk("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst       = 1'b0;
        req_valid   = 1'b0;
        req_link_id = '0;
        seg_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", seg_valid, 0);
        chk("rst_en", enc_id_enable, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_done_err", {done, err}, 0);
        n_rst = 1'b1;
        @(negedge clk);

        frame(6'h04, 6'h00, 1'b0, 1'b0, 0);
        frame(6'h18, 6'h00, 1'b0, 1'b0, 0);
        chk("frame_len_3788", frame_len, 13'h0ecc);
        frame(6'h05, 6'h00, 1'b0, 1'b1, 0);
        frame(6'h02, 6'h00, 1'b0, 1'b0, 0);
        frame(6'h1e, 6'h00, 1'b0, 1'b0, 100);
        frame(6'h14, 6'h0d, 1'b1, 1'b0, 0);
        frame(6'h0d, 6'h00, 1'b0, 1'b0, 0);
        frame(6'd34, 6'h00, 1'b0, 1'b0, 0);
        frame(6'd35, 6'h00, 1'b0, 1'b0, 0);
        frame(6'd3,  6'h00, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            frame(6'($urandom_range(0, 40)), 6'h00, 1'b0, 1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
